// File: rtl/instruction_sequencer.sv
// Instruction sequencer: a small program memory plus a fetch FSM that streams
// 6-bit instruction words to a decoder, either free-running (one word per
// clock) or one word per step pulse. A HALT word or the end of memory ends
// the program. All outputs are registered.
module instruction_sequencer #(
    parameter int          DEPTH     = 16,
    parameter logic [5:0]  HALT_WORD = 6'b111111,
    parameter logic [5:0]  NOP_WORD  = 6'b000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [5:0]               load_data,
    input  logic                     start,
    input  logic                     step_mode,
    input  logic                     step,
    input  logic                     abort,
    output logic [5:0]               instruction,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state;

    // Program memory. Every word must return to HALT_WORD the instant reset
    // asserts, so this is a register array rather than a block RAM.
    logic [5:0] mem [DEPTH];

    logic          load_state;   // IDLE or DONE: memory may be written, start accepted
    logic          write_en;
    logic          fetch_now;    // a fetch happens on the coming edge
    logic [AW-1:0] fetch_addr;
    logic [5:0]    fetch_word;
    logic          fetch_halt;
    logic          fetch_last;
    logic          fetch_ends;   // this fetch terminates the program
    logic [AW-1:0] fetch_next_pc;

    // Decode the control conditions for this cycle; abort overrides everything.
    always_comb begin
        load_state = (state == IDLE) || (state == DONE);
        write_en   = load_state && load_en && !start && !abort;
        fetch_now  = 1'b0;
        if (!abort) begin
            if (load_state)
                fetch_now = start && !step_mode;
            else if (state == RUN)
                fetch_now = 1'b1;
            else
                fetch_now = step;
        end
    end

    // Fetch datapath: a start always fetches address 0, otherwise the word at pc.
    always_comb begin
        fetch_addr = load_state ? '0 : pc;
        fetch_word = mem[fetch_addr];
        fetch_halt = (fetch_word == HALT_WORD);
        fetch_last = (fetch_addr == LAST_ADDR);
        fetch_ends = fetch_halt || fetch_last;
        // A HALT leaves pc on the HALT address; a valid last word wraps pc to 0.
        if (fetch_halt)
            fetch_next_pc = fetch_addr;
        else if (fetch_last)
            fetch_next_pc = '0;
        else
            fetch_next_pc = fetch_addr + AW'(1);
    end

    // Program memory writes; reset refills every word with HALT_WORD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= HALT_WORD;
        end else if (write_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Sequencer FSM with registered instruction, valid, pc, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Nothing is live unless a valid fetch happens this edge.
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;

            if (abort) begin
                state <= IDLE;
                pc    <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (fetch_now) begin
                instruction <= fetch_halt ? NOP_WORD : fetch_word;
                instr_valid <= !fetch_halt;
                pc          <= fetch_next_pc;
                if (fetch_ends) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    // Step mode stays in STEP_WAIT; a free-running start or RUN stays in RUN.
                    state <= (state == STEP_WAIT) ? STEP_WAIT : RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
            end else if (load_state && start) begin
                // Step-mode start: arm at address 0 and wait for the first step.
                state <= STEP_WAIT;
                pc    <= '0;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer: reset, empty-program start,
// free-run, step mode, abort with a colliding load, full-memory wrap and a
// mid-run reset. Expected values are hand-computed constants.
module tb_instruction_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [5:0]    load_data;
    logic          start;
    logic          step_mode;
    logic          step;
    logic          abort;
    logic [5:0]    instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    instruction_sequencer #(
        .DEPTH(DEPTH),
        .HALT_WORD(6'b111111),
        .NOP_WORD(6'b000000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .start(start),
        .step_mode(step_mode),
        .step(step),
        .abort(abort),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc(pc),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible output state in one call.
    task automatic chk_out(input string tag, input logic [5:0] e_instr, input logic e_valid,
                           input logic [AW-1:0] e_pc, input logic e_busy, input logic e_done);
        chk({tag, ".instr"}, 32'(instruction), 32'(e_instr));
        chk({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
        chk({tag, ".pc"},    32'(pc),          32'(e_pc));
        chk({tag, ".busy"},  32'(busy),        32'(e_busy));
        chk({tag, ".done"},  32'(done),        32'(e_done));
        $display("txn %-12s instr=%02h valid=%0d pc=%0d busy=%0d done=%0d",
                 tag, instruction, instr_valid, pc, busy, done);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [5:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;

        // Reset values apply before any clock edge.
        #2;
        chk_out("reset", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_out("idle", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);

        // Empty program: address 0 holds HALT.
        start = 1'b1; tick(); start = 1'b0;
        chk_out("empty", 6'h00, 1'b0, 4'd0, 1'b0, 1'b1);

        // Three-word program, free-run.
        load_word(4'd0, 6'h05);
        load_word(4'd1, 6'h09);
        load_word(4'd2, 6'h3F);
        start = 1'b1; tick(); start = 1'b0;
        chk_out("run0", 6'h05, 1'b1, 4'd1, 1'b1, 1'b0);
        tick();
        chk_out("run1", 6'h09, 1'b1, 4'd2, 1'b1, 1'b0);
        tick();
        chk_out("run_halt", 6'h00, 1'b0, 4'd2, 1'b0, 1'b1);
        tick();
        chk_out("done_hold", 6'h00, 1'b0, 4'd2, 1'b0, 1'b1);

        // Step mode; step_mode is dropped mid-program and must be ignored.
        step_mode = 1'b1; start = 1'b1; tick(); start = 1'b0; step_mode = 1'b0;
        chk_out("st_arm", 6'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        tick(); tick();
        chk_out("st_wait", 6'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step = 1'b1; tick(); step = 1'b0;
        chk_out("st1", 6'h05, 1'b1, 4'd1, 1'b1, 1'b0);
        tick();
        chk_out("st1_gap", 6'h00, 1'b0, 4'd1, 1'b1, 1'b0);
        tick();
        step = 1'b1; tick(); step = 1'b0;
        chk_out("st2", 6'h09, 1'b1, 4'd2, 1'b1, 1'b0);
        tick(); tick();
        step = 1'b1; tick(); step = 1'b0;
        chk_out("st3_halt", 6'h00, 1'b0, 4'd2, 1'b0, 1'b1);

        // Abort on the second valid cycle, with a load attempt in the same cycle.
        start = 1'b1; tick(); start = 1'b0;
        chk_out("ab_run0", 6'h05, 1'b1, 4'd1, 1'b1, 1'b0);
        tick();
        chk_out("ab_run1", 6'h09, 1'b1, 4'd2, 1'b1, 1'b0);
        abort = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 6'h2A;
        tick();
        abort = 1'b0; load_en = 1'b0;
        chk_out("abort", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        // Abort in IDLE beats both start and load.
        abort = 1'b1; start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 6'h2A;
        tick();
        abort = 1'b0; start = 1'b0; load_en = 1'b0;
        chk_out("abort_idle", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk_out("no_write", 6'h05, 1'b1, 4'd1, 1'b1, 1'b0);
        tick(); tick();
        chk_out("ab_done", 6'h00, 1'b0, 4'd2, 1'b0, 1'b1);

        // Full memory of 0x04: 16 valid words, pc wraps to 0 with done on the last.
        for (int i = 0; i < DEPTH; i++)
            load_word(AW'(i), 6'h04);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_out($sformatf("full%0d", i), 6'h04, 1'b1, AW'((i + 1) % DEPTH),
                    (i != DEPTH - 1), (i == DEPTH - 1));
            if (i != DEPTH - 1) tick();
        end
        tick();
        chk_out("full_end", 6'h00, 1'b0, 4'd0, 1'b0, 1'b1);

        // Reset mid-run: outputs clear without a clock edge; memory returns to HALT.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk_out("rst_run", 6'h04, 1'b1, 4'd2, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("rst_async", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk_out("rst_start", 6'h00, 1'b0, 4'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
